// File: rtl/l1_mau.sv
// Memory access unit below the L1D: splits line refills into sequential word reads
// and forwards single-word non-cacheable reads and write-through writes.
module l1_mau #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_SIZE  = 128,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mau_req_val,
    input  logic                  mau_req_nc,
    input  logic                  mau_req_we,
    input  logic [ADDR_WIDTH-1:0] mau_req_addr,
    input  logic [DATA_WIDTH-1:0] mau_req_wdata,
    input  logic [BE_WIDTH-1:0]   mau_req_be,
    output logic                  mau_req_ack,
    output logic                  mau_ack_nc,
    output logic                  mau_ack_we,
    output logic [LINE_SIZE-1:0]  mau_ack_data,
    output logic                  mem_req_val,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [BE_WIDTH-1:0]   mem_req_be,
    input  logic                  mem_req_ack,
    input  logic                  mem_rsp_val,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data
);
    // state   | meaning
    // IDLE    | waiting for an L1D request (ignored for one cycle after DONE)
    // WR      | single-word write presented on the memory bus
    // RD_REQ  | read request (nc word or current refill beat) on the memory bus
    // RD_WAIT | request accepted, waiting for mem_rsp_val
    // DONE    | one-cycle completion pulse to the L1D
    localparam int BEATS    = LINE_SIZE / DATA_WIDTH;
    localparam int BEAT_W   = $clog2(BEATS);
    localparam int OFF_W    = $clog2(BE_WIDTH);
    localparam int LINE_OFF = OFF_W + BEAT_W;

    typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, DONE} state_t;

    state_t                         state;
    logic                           guard;
    logic                           nc_q;
    logic                           we_q;
    logic [ADDR_WIDTH-LINE_OFF-1:0] base_q;
    logic [BEAT_W-1:0]              beat_cnt;
    logic [BEAT_W-1:0]              beat_nxt;
    logic [LINE_SIZE-1:0]           line;
    logic [OFF_W-1:0]               req_off;
    logic [ADDR_WIDTH-1:0]          word_addr;
    logic [ADDR_WIDTH-1:0]          line_addr;

    assign req_off   = mau_req_addr[OFF_W-1:0];
    assign word_addr = {mau_req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign line_addr = {mau_req_addr[ADDR_WIDTH-1:LINE_OFF], {LINE_OFF{1'b0}}};
    assign beat_nxt  = beat_cnt + BEAT_W'(1);

    // line is cleared at capture, so a write completes with all-zero data
    assign mau_ack_nc   = mau_req_ack & nc_q;
    assign mau_ack_we   = mau_req_ack & we_q;
    assign mau_ack_data = mau_req_ack ? line : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            guard         <= 1'b0;
            nc_q          <= 1'b0;
            we_q          <= 1'b0;
            base_q        <= '0;
            beat_cnt      <= '0;
            line          <= '0;
            mau_req_ack   <= 1'b0;
            mem_req_val   <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_be    <= '0;
        end else begin
            mau_req_ack <= 1'b0;
            case (state)
                IDLE: begin
                    guard <= 1'b0;
                    if (mau_req_val && !guard) begin
                        nc_q        <= mau_req_nc;
                        we_q        <= mau_req_we;
                        base_q      <= mau_req_addr[ADDR_WIDTH-1:LINE_OFF];
                        beat_cnt    <= '0;
                        line        <= '0;
                        mem_req_val <= 1'b1;
                        mem_req_we  <= mau_req_we;
                        if (mau_req_we) begin
                            mem_req_addr  <= word_addr;
                            mem_req_be    <= mau_req_be << req_off;
                            mem_req_wdata <= mau_req_wdata << {req_off, 3'b000};
                            state         <= WR;
                        end else begin
                            mem_req_addr  <= mau_req_nc ? word_addr : line_addr;
                            mem_req_be    <= '1;
                            mem_req_wdata <= '0;
                            state         <= RD_REQ;
                        end
                    end
                end
                WR, RD_REQ: begin
                    if (mem_req_ack) begin
                        mem_req_val   <= 1'b0;
                        mem_req_we    <= 1'b0;
                        mem_req_addr  <= '0;
                        mem_req_wdata <= '0;
                        mem_req_be    <= '0;
                        if (state == WR) begin
                            state       <= DONE;
                            mau_req_ack <= 1'b1;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (mem_rsp_val) begin
                        if (nc_q) begin
                            line        <= {mem_rsp_data, {(LINE_SIZE-DATA_WIDTH){1'b0}}};
                            state       <= DONE;
                            mau_req_ack <= 1'b1;
                        end else begin
                            line[int'(beat_cnt)*DATA_WIDTH +: DATA_WIDTH] <= mem_rsp_data;
                            if (&beat_cnt) begin
                                beat_cnt    <= '0;
                                state       <= DONE;
                                mau_req_ack <= 1'b1;
                            end else begin
                                beat_cnt     <= beat_nxt;
                                mem_req_val  <= 1'b1;
                                mem_req_we   <= 1'b0;
                                mem_req_be   <= '1;
                                mem_req_addr <= {base_q, beat_nxt, {OFF_W{1'b0}}};
                                state        <= RD_REQ;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    guard <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // a response with no read outstanding indicates a broken memory model
    assert property (@(posedge clk) disable iff (!rst_n) mem_rsp_val |-> state == RD_WAIT);

endmodule
